// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter closing the loop around an array of JK cells.
// Optional JK_MOD_COUNTER_SATURATE_EN holds at the terminal values instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] n;
  logic             at_top;
  logic             at_bot;

  assign at_top = (q == MAX);
  assign at_bot = (q == '0);

  always_comb begin
    n = q;
    if (rst) begin
      n = '0;
    end else if (load) begin
      n = (din > MAX) ? MAX : din;
    end else if (en && up) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
      n = at_top ? q : q + WIDTH'(1);
`else
      n = at_top ? '0 : q + WIDTH'(1);
`endif
    end else if (en) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
      n = at_bot ? q : q - WIDTH'(1);
`else
      n = at_bot ? MAX : q - WIDTH'(1);
`endif
    end
  end

  // Counting toggles only the changing bits; load uses set/clear.
  always_comb begin
    j_o = q ^ n;
    k_o = q ^ n;
    if (rst) begin
      j_o = '0;
      k_o = '1;
    end else if (load) begin
      j_o = n;
      k_o = ~n;
    end
  end

  assign tc = en && !load && !rst && (up ? at_top : at_bot);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({j_o[i], k_o[i]})
          2'b00: q[i] <= q[i];
          2'b01: q[i] <= 1'b0;
          2'b10: q[i] <= 1'b1;
          2'b11: q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule
